// File: rtl/mult_proc_pkg.sv
// Shared definitions for the multi-cycle processor control path:
// opcodes, ALU codes, FSM states and instruction field positions.
package mult_proc_pkg;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] op);
    logic [1:0] r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_unit_checker.sv
// Bus-protocol properties for control_unit: single bus driver per cycle
// and a zero-or-one-hot register write enable.
module control_unit_checker (
  input logic       clock,
  input logic       reset,
  input logic [7:0] r_in,
  input logic [7:0] r_out,
  input logic       din_out,
  input logic       g_out
);

  a_single_driver: assert property (@(posedge clock) disable iff (reset)
    $onehot0({r_out, din_out, g_out}));

  a_r_in_onehot0: assert property (@(posedge clock) disable iff (reset)
    $onehot0(r_in));

endmodule

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  // one-hot expansion of the register index
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Control FSM for a small multi-cycle processor: sequences mv, mvi and
// two-operand ALU instructions over a shared bus, one state per clock.
module control_unit
  import mult_proc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [9:0] ir,
  output logic       ir_write,
  output logic [7:0] r_in,
  output logic [7:0] r_out,
  output logic       din_out,
  output logic       a_in,
  output logic       g_in,
  output logic       g_out,
  output logic [1:0] alu_op,
  output logic       done,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic [2:0] x_idx, y_idx;
  logic [7:0] x_hot, y_hot;
  logic       active;

  assign opcode = ir[OP_MSB:OP_LSB];
  assign x_idx  = ir[X_MSB:X_LSB];
  assign y_idx  = ir[Y_MSB:Y_LSB];
  assign active = (state_q != S_IDLE);

  dec3to8 u_dec_x (.idx(x_idx), .en(active), .onehot(x_hot));
  dec3to8 u_dec_y (.idx(y_idx), .en(active), .onehot(y_hot));

  // next-state selection; run only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
        else     state_d = S_IDLE;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        if (is_alu_op(opcode)) state_d = S_T2;
        else                   state_d = S_IDLE;
      end
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register, cleared asynchronously so an instruction aborts at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // control outputs decoded from state and ir; only one bus driver per state
  always_comb begin
    ir_write = 1'b0;
    r_in     = 8'h00;
    r_out    = 8'h00;
    din_out  = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    alu_op   = ALU_ADD;
    done     = 1'b0;
    busy     = active;
    case (state_q)
      S_T0: ir_write = 1'b1;
      S_T1: begin
        case (opcode)
          OP_MV: begin
            r_out = y_hot;
            r_in  = x_hot;
            done  = 1'b1;
          end
          OP_MVI: begin
            din_out = 1'b1;
            r_in    = x_hot;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            r_out = x_hot;
            a_in  = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        if (is_alu_op(opcode)) begin
          r_out  = y_hot;
          g_in   = 1'b1;
          alu_op = alu_code(opcode);
        end else begin
          r_out = 8'h00;
        end
      end
      S_T3: begin
        if (is_alu_op(opcode)) begin
          g_out = 1'b1;
          r_in  = x_hot;
          done  = 1'b1;
        end else begin
          r_in = 8'h00;
        end
      end
      default: busy = active;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instruction sequences push the
// expected per-cycle output vector; a negedge monitor pops and compares.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [9:0] ir;
  logic       ir_write, din_out, a_in, g_in, g_out, done, busy;
  logic [7:0] r_in, r_out;
  logic [1:0] alu_op;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .run(run), .ir(ir),
    .ir_write(ir_write), .r_in(r_in), .r_out(r_out), .din_out(din_out),
    .a_in(a_in), .g_in(g_in), .g_out(g_out), .alu_op(alu_op),
    .done(done), .busy(busy)
  );

  control_unit_checker chk (
    .clock(clock), .reset(reset), .r_in(r_in), .r_out(r_out),
    .din_out(din_out), .g_out(g_out)
  );

  // {ir_write, r_in, r_out, din_out, a_in, g_in, g_out, alu_op, done, busy}
  logic [24:0] act;
  assign act = {ir_write, r_in, r_out, din_out, a_in, g_in, g_out, alu_op, done, busy};

  logic [24:0] exp_q[$];
  string       name_q[$];
  int          done_cyc[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  localparam logic [24:0] ZV = 25'd0;

  function automatic logic [24:0] ev(input logic irw, input logic [7:0] rin,
      input logic [7:0] rout, input logic din, input logic a, input logic gi,
      input logic go, input logic [1:0] alu, input logic dn, input logic bz);
    return {irw, rin, rout, din, a, gi, go, alu, dn, bz};
  endfunction

  // expected T0 vector: ir_write and busy only
  logic [24:0] t0v;
  assign t0v = ev(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

  task automatic step(input logic [24:0] e, input string nm);
    @(posedge clock);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor: bus invariants every cycle, scoreboard pop when an entry is due
  always @(negedge clock) begin
    logic [24:0] e;
    string       nm;
    n_tests++;
    if (!$onehot0({r_out, din_out, g_out})) begin
      n_fail++;
      $display("FAIL bus_driver cyc=%0d: got r_out=%h din=%b g_out=%b, required at most one", cyc, r_out, din_out, g_out);
    end
    n_tests++;
    if (!$onehot0(r_in)) begin
      n_fail++;
      $display("FAIL r_in_onehot cyc=%0d: got %h, required zero or one-hot", cyc, r_in);
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, act, e);
      end
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    ir    = 10'd0;
    step(ZV, "reset_idle");
    run = 1'b1;
    ir  = 10'b0010_001_010;
    step(ZV, "reset_ignores_run");

    // release reset with run already high: first T0 follows next edge (mvi R3)
    reset = 1'b0;
    ir    = 10'b0001_011_000;
    step(t0v, "mvi_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "mvi_t1");
    step(ZV, "mvi_idle");

    // sub R5,R2
    run = 1'b1;
    ir  = 10'b0011_101_010;
    step(t0v, "sub_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1), "sub_t1");
    step(ev(1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1), "sub_t2");
    step(ev(1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1), "sub_t3");
    step(ZV, "sub_idle");

    // add R1,R2 aborted by reset asserted inside T2
    run = 1'b1;
    ir  = 10'b0010_001_010;
    step(t0v, "add_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1), "add_t1");
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.push_back(ZV);
    name_q.push_back("abort_in_t2");
    step(ZV, "abort_held");
    reset = 1'b0;
    step(ZV, "abort_release");
    step(ZV, "abort_stay_idle1");
    step(ZV, "abort_stay_idle2");

    // back-to-back with run held: mv R5,R6 / add R3,R3 / mv R2,R2
    done_cyc.delete();
    run = 1'b1;
    ir  = 10'b0000_101_110;
    step(t0v, "b2b_mv1_t0");
    step(ev(1'b0, 8'h20, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "b2b_mv1_t1");
    step(ZV, "b2b_gap1");
    ir = 10'b0010_011_011;
    step(t0v, "b2b_add_t0");
    step(ev(1'b0, 8'h00, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1), "b2b_add_t1");
    step(ev(1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), "b2b_add_t2");
    step(ev(1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1), "b2b_add_t3");
    step(ZV, "b2b_gap2");
    ir = 10'b0000_010_010;
    step(t0v, "b2b_mv2_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "b2b_mv2_t1");
    step(ZV, "b2b_end");
    @(negedge clock);
    #1;
    n_tests++;
    if (done_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d required 3", done_cyc.size());
    end else begin
      n_tests++;
      if ((done_cyc[1] - done_cyc[0]) != 5 || (done_cyc[2] - done_cyc[1]) != 3) begin
        n_fail++;
        $display("FAIL b2b_done_gaps: got %0d,%0d required 5,3",
                 done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
      end
    end

    // NOP opcode 1111
    run = 1'b1;
    ir  = 10'b1111_000_000;
    step(t0v, "nop_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1), "nop_t1");
    step(ZV, "nop_idle");

    // and R7,R0 with a run glitch in T2
    run = 1'b1;
    ir  = 10'b0100_111_000;
    step(t0v, "and_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1), "and_t1");
    step(ev(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1), "and_t2");
    run = 1'b1;
    step(ev(1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1), "and_t3_glitch");
    run = 1'b0;
    step(ZV, "and_idle");
    step(ZV, "and_idle_stays");

    // or R0,R1
    run = 1'b1;
    ir  = 10'b0101_000_001;
    step(t0v, "or_t0");
    run = 1'b0;
    step(ev(1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1), "or_t1");
    step(ev(1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1), "or_t2");
    step(ev(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1), "or_t3");
    step(ZV, "or_idle");

    // random traffic: only the bus invariants are checked here
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      run   = 1'($urandom_range(0, 1));
      ir    = 10'($urandom);
      reset = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
    end
    reset = 1'b0;
    run   = 1'b0;

    @(posedge clock);
    @(negedge clock);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
